peripheral_mem_arbiter: RTL and testbench
=========================================

// Module: peripheral_mem_arbiter
// PURPOSE
//   Shares the peripheral's single memory port (fixed-latency, Avalon-style) between two requesters:
//   host (port 0) and DMA engine (port 1). Grants one request per cycle and stalls the loser via waitrequest.
//   Tracks in-flight reads and routes each read_valid back to the requester that issued it.
//   Sits between the bus fabric / DMA and the peripheral top-level mem_* port.
// PARAMETERS
//   DATAWIDTH  32  data width of all data buses
//   ADDRWIDTH  8   word address width (256-deep memory)
//   LATENCY    1   fixed read latency of the shared memory port, cycles; legal range 1..8
// PORTS
//   clk              in   1          clock
//   reset            in   1          asynchronous, active-high reset
//   h_read/h_write   in   1          host read / write request
//   h_address        in   ADDRWIDTH  host word address
//   h_data_in        in   DATAWIDTH  host write data
//   h_waitrequest    out  1          1 = host request not accepted this cycle; hold it
//   h_read_valid     out  1          host read data valid
//   h_data_out       out  DATAWIDTH  host read data
//   d_*              --   --         DMA port, identical set and meaning to h_*
//   m_read/m_write   out  1          read / write issued to shared memory port
//   m_address        out  ADDRWIDTH  issued address
//   m_data_out       out  DATAWIDTH  issued write data
//   m_read_valid     in   1          memory read data valid
//   m_data_in        in   DATAWIDTH  memory read data
// BEHAVIOUR
//   - Request: req_x = x_read | x_write. If read and write are both set, the write is issued and the read is ignored.
//   - Arbitration is combinational, zero-latency: the winner's command drives m_* in the same cycle.
//     Winner waitrequest = 0; loser waitrequest = 1; idle requester waitrequest = 0.
//   - Round robin: last_grant register, reset value DMA, so the host wins the first tie.
//     On a tie, grant the requester that is not last_grant. With a single requester, grant it.
//     last_grant updates only on a cycle in which a transfer is issued.
//   - m_read, m_write and m_address/m_data_out are 0 when nothing is granted.
//   - Read tag pipe: LATENCY stages of {valid,id}. Stage 0 loads {m_read, winner}; the pipe shifts every cycle.
//   - Read return: on m_read_valid, stage LATENCY-1 selects the owner. owner read_valid = 1; the other stays 0.
//     h_data_out = d_data_out = m_data_in (broadcast; only read_valid is qualified).
//   - m_read_valid with stage LATENCY-1 invalid: data dropped; simulation assertion fires.
//     Stage valid without m_read_valid is also an assertion error.
//   - Throughput: back-to-back reads/writes from alternating requesters, one per cycle, with no bubbles.
//   - Reset (async assert): last_grant=DMA, all tag stages invalid. While reset is high:
//     h/d_waitrequest=1, m_read=m_write=0, h/d_read_valid=0.
//     Reset mid-operation drops in-flight reads; no read_valid is produced for them afterwards.
// CONFIGURATION
//   MEM_ARB_FIXED_PRIORITY_EN defined:
//     host always wins ties; DMA is granted only when the host is idle.
//     last_grant is still maintained, but it does not affect the grant.
//   Not defined: round robin as above.
// STRUCTURE
//   Package peripheral_mem_arb_pkg:
//     typedef enum logic {ARB_HOST=1'b0, ARB_DMA=1'b1} arb_id_t;
//     typedef struct packed {logic valid; arb_id_t id;} rd_tag_t;
//     localparam MAX_LATENCY = 8.
//   Sub-module peripheral_rd_tag_pipe:
//     parameterised LATENCY shift register of rd_tag_t with async reset;
//     in: tag; out: tag at stage LATENCY-1.
//   Top: grant logic, last_grant register, m_* mux, return routing.
// TESTING
//   1. Reset asserted mid-stream with h_read=1 -> h/d_waitrequest=1 and m_read=0 during reset.
//      After release, no read_valid for the dropped read.
//   2. Host alone, write 0xA5A5_0001 to addr 0x10, then read 0x10 -> m_write on cycle 0, waitrequest=0.
//      h_read_valid=1 with 0xA5A5_0001 exactly LATENCY cycles after m_read; d_read_valid stays 0.
//   3. Host and DMA read every cycle for 8 cycles (addr 0x01 / 0x02) -> grants alternate H,D,H,D...
//      The first grant goes to host. Each loser sees waitrequest=1, and each read_valid goes to the correct requester.
//   4. DMA write 0x0000_00FF to addr 0x20 with host idle -> issued in the same cycle, d_waitrequest=0.
//      last_grant=DMA, so the next tie goes to host.
//   5. Same requester sets read=1 and write=1 together -> only m_write is issued; no read tag is loaded.
//   6. With MEM_ARB_FIXED_PRIORITY_EN, both requesting for 5 cycles -> host granted all 5 cycles.
//      d_waitrequest=1 throughout; DMA is granted on the first host-idle cycle.

Source files
------------

// File: rtl/peripheral_mem_arb_pkg.sv
// rtl/peripheral_mem_arb_pkg.sv - shared types for the peripheral memory arbiter
package peripheral_mem_arb_pkg;

    typedef enum logic {ARB_HOST = 1'b0, ARB_DMA = 1'b1} arb_id_t;

    typedef struct packed {
        logic    valid;
        arb_id_t id;
    } rd_tag_t;

    localparam int MAX_LATENCY = 8;

    function automatic arb_id_t other_id(input arb_id_t id);
        return (id == ARB_HOST) ? ARB_DMA : ARB_HOST;
    endfunction

endpackage

// File: rtl/peripheral_mem_arbiter_if.sv
// rtl/peripheral_mem_arbiter_if.sv - requester-side Avalon-style port of the memory arbiter
interface peripheral_mem_arbiter_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 8
) ();

    logic                 read;
    logic                 write;
    logic [ADDRWIDTH-1:0] address;
    logic [DATAWIDTH-1:0] data_in;
    logic                 waitrequest;
    logic                 read_valid;
    logic [DATAWIDTH-1:0] data_out;

    modport master (
        output read, write, address, data_in,
        input  waitrequest, read_valid, data_out
    );

    modport slave (
        input  read, write, address, data_in,
        output waitrequest, read_valid, data_out
    );

endinterface

// File: rtl/peripheral_rd_tag_pipe.sv
// rtl/peripheral_rd_tag_pipe.sv - fixed-depth shift register tracking the owner of each in-flight read
module peripheral_rd_tag_pipe
    import peripheral_mem_arb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [LATENCY-1:0] stage_q;
    rd_tag_t [LATENCY-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = tag_in;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[LATENCY-1];

endmodule

// File: rtl/peripheral_mem_arbiter.sv
// rtl/peripheral_mem_arbiter.sv - two-requester arbiter for the shared fixed-latency memory port
// Optional MEM_ARB_FIXED_PRIORITY_EN: host always wins ties instead of round robin.
module peripheral_mem_arbiter
    import peripheral_mem_arb_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 8,
    parameter int LATENCY   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    peripheral_mem_arbiter_if.slave h_if,
    peripheral_mem_arbiter_if.slave d_if,
    output logic                  m_read,
    output logic                  m_write,
    output logic [ADDRWIDTH-1:0]  m_address,
    output logic [DATAWIDTH-1:0]  m_data_out,
    input  logic                  m_read_valid,
    input  logic [DATAWIDTH-1:0]  m_data_in
);

    logic    h_req;
    logic    d_req;
    logic    grant_h;
    logic    grant_d;
    logic    any_grant;
    arb_id_t winner;
    arb_id_t last_grant_q;
    arb_id_t last_grant_d;
    rd_tag_t tag_in;
    rd_tag_t tag_out;

    always_comb begin
        h_req   = h_if.read | h_if.write;
        d_req   = d_if.read | d_if.write;
        grant_h = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            grant_h = h_req;
            grant_d = d_req & ~h_req;
`else
            if (h_req && d_req) begin
                grant_h = (other_id(last_grant_q) == ARB_HOST);
                grant_d = ~grant_h;
            end else begin
                grant_h = h_req;
                grant_d = d_req;
            end
`endif
        end
        any_grant    = grant_h | grant_d;
        winner       = grant_d ? ARB_DMA : ARB_HOST;
        last_grant_d = any_grant ? winner : last_grant_q;
    end

    // A simultaneous read+write from one requester issues only the write.
    always_comb begin
        m_read     = 1'b0;
        m_write    = 1'b0;
        m_address  = '0;
        m_data_out = '0;
        if (grant_h) begin
            m_write    = h_if.write;
            m_read     = h_if.read & ~h_if.write;
            m_address  = h_if.address;
            m_data_out = h_if.data_in;
        end else if (grant_d) begin
            m_write    = d_if.write;
            m_read     = d_if.read & ~d_if.write;
            m_address  = d_if.address;
            m_data_out = d_if.data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= ARB_DMA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign tag_in = '{valid: m_read, id: winner};

    peripheral_rd_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign h_if.waitrequest = reset | (h_req & ~grant_h);
    assign d_if.waitrequest = reset | (d_req & ~grant_d);

    // Read data is broadcast; only read_valid is steered to the issuing requester.
    assign h_if.read_valid = ~reset & m_read_valid & tag_out.valid & (tag_out.id == ARB_HOST);
    assign d_if.read_valid = ~reset & m_read_valid & tag_out.valid & (tag_out.id == ARB_DMA);
    assign h_if.data_out   = m_data_in;
    assign d_if.data_out   = m_data_in;

    a_no_orphan_return: assert property (@(posedge clk) disable iff (reset)
        m_read_valid |-> tag_out.valid);
    a_no_missing_return: assert property (@(posedge clk) disable iff (reset)
        tag_out.valid |-> m_read_valid);

endmodule

// File: tb/tb_peripheral_mem_arbiter.sv
// tb/tb_peripheral_mem_arbiter.sv - directed self-checking bench for peripheral_mem_arbiter
module tb_peripheral_mem_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_read;
    logic        m_write;
    logic [7:0]  m_address;
    logic [31:0] m_data_out;
    logic        m_read_valid;
    logic [31:0] m_data_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peripheral_mem_arbiter_if #(.DATAWIDTH(32), .ADDRWIDTH(8)) h_if ();
    peripheral_mem_arbiter_if #(.DATAWIDTH(32), .ADDRWIDTH(8)) d_if ();

    peripheral_mem_arbiter #(
        .DATAWIDTH (32),
        .ADDRWIDTH (8),
        .LATENCY   (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .h_if         (h_if),
        .d_if         (d_if),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_data_out   (m_data_out),
        .m_read_valid (m_read_valid),
        .m_data_in    (m_data_in)
    );

    // Memory model with fixed read latency LAT
    typedef struct packed {logic v; logic [31:0] d;} mrsp_t;
    logic [31:0]         mem [256];
    mrsp_t [LAT-1:0]     mpipe;

    always_ff @(posedge clk) begin
        if (m_write) mem[m_address] <= m_data_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mpipe <= '0;
        end else begin
            mpipe[0] <= '{v: m_read, d: mem[m_address]};
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end

    assign m_read_valid = mpipe[LAT-1].v;
    assign m_data_in    = mpipe[LAT-1].d;

    task automatic drive(input logic hr, input logic hw, input logic [7:0] ha, input logic [31:0] hd,
                         input logic dr, input logic dw, input logic [7:0] da, input logic [31:0] dd);
        h_if.read = hr; h_if.write = hw; h_if.address = ha; h_if.data_in = hd;
        d_if.read = dr; d_if.write = dw; d_if.address = da; d_if.data_in = dd;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk); reset = 1'b1; idle();
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); drive(1, 0, 8'h05, 32'h0, 1, 0, 8'h06, 32'h0); #1;
        checks++; if (h_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_h_wait: got %b exp 1", h_if.waitrequest); end
        checks++; if (d_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_d_wait: got %b exp 1", d_if.waitrequest); end
        checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin errors++; $display("FAIL rst_m_cmd: got %b%b exp 00", m_read, m_write); end
        checks++; if (h_if.read_valid !== 1'b0 || d_if.read_valid !== 1'b0) begin errors++; $display("FAIL rst_rv: got %b%b exp 00", h_if.read_valid, d_if.read_valid); end
        @(negedge clk); reset = 1'b0; drive(1, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0); #1;
        checks++; if (m_read !== 1'b1) begin errors++; $display("FAIL rst_rel_read: got %b exp 1", m_read); end
        @(negedge clk); reset = 1'b1; #1;
        checks++; if (h_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_mid_wait: got %b exp 1", h_if.waitrequest); end
        checks++; if (m_read !== 1'b0) begin errors++; $display("FAIL rst_mid_mread: got %b exp 0", m_read); end
        checks++; if (h_if.read_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rv: got %b exp 0", h_if.read_valid); end
        @(negedge clk); reset = 1'b0; idle();
        for (int i = 0; i <= LAT; i++) begin
            #1;
            checks++; if (h_if.read_valid !== 1'b0 || d_if.read_valid !== 1'b0) begin errors++; $display("FAIL rst_dropped_rv: got %b%b exp 00", h_if.read_valid, d_if.read_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_host_alone();
        @(negedge clk); drive(0, 1, 8'h10, 32'hA5A5_0001, 0, 0, 8'h00, 32'h0); #1;
        checks++; if (m_write !== 1'b1 || m_read !== 1'b0) begin errors++; $display("FAIL host_wr_cmd: got rw=%b%b exp 01", m_read, m_write); end
        checks++; if (m_address !== 8'h10 || m_data_out !== 32'hA5A5_0001) begin errors++; $display("FAIL host_wr_bus: got %h/%h exp 10/a5a50001", m_address, m_data_out); end
        checks++; if (h_if.waitrequest !== 1'b0) begin errors++; $display("FAIL host_wr_wait: got %b exp 0", h_if.waitrequest); end
        @(negedge clk); drive(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0); #1;
        checks++; if (m_read !== 1'b1 || m_address !== 8'h10 || h_if.waitrequest !== 1'b0) begin errors++; $display("FAIL host_rd_cmd: got rd=%b addr=%h wait=%b exp 1/10/0", m_read, m_address, h_if.waitrequest); end
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk); idle(); #1;
            if (i == LAT) begin
                checks++; if (h_if.read_valid !== 1'b1 || h_if.data_out !== 32'hA5A5_0001) begin errors++; $display("FAIL host_rd_ret: got rv=%b data=%h exp 1/a5a50001", h_if.read_valid, h_if.data_out); end
            end else begin
                checks++; if (h_if.read_valid !== 1'b0) begin errors++; $display("FAIL host_rd_early: got %b exp 0", h_if.read_valid); end
            end
            checks++; if (d_if.read_valid !== 1'b0) begin errors++; $display("FAIL host_rd_dma_rv: got %b exp 0", d_if.read_valid); end
        end
    endtask

    task automatic test_round_robin();
        logic exp_h;
        @(negedge clk); drive(0, 1, 8'h01, 32'h1111_0001, 0, 0, 8'h00, 32'h0);
        @(negedge clk); drive(0, 1, 8'h02, 32'h2222_0002, 0, 0, 8'h00, 32'h0);
        apply_reset();
        for (int k = 0; k < 8 + LAT; k++) begin
            @(negedge clk);
            if (k < 8) drive(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0);
            else idle();
            #1;
            if (k < 8) begin
                exp_h = (k % 2 == 0);
                checks++; if (h_if.waitrequest !== !exp_h || d_if.waitrequest !== exp_h) begin errors++; $display("FAIL rr_wait[%0d]: got h=%b d=%b exp h=%b d=%b", k, h_if.waitrequest, d_if.waitrequest, !exp_h, exp_h); end
                checks++; if (m_read !== 1'b1 || m_address !== (exp_h ? 8'h01 : 8'h02)) begin errors++; $display("FAIL rr_addr[%0d]: got rd=%b addr=%h exp 1/%h", k, m_read, m_address, exp_h ? 8'h01 : 8'h02); end
            end
            if (k >= LAT) begin
                exp_h = ((k - LAT) % 2 == 0);
                checks++; if (h_if.read_valid !== exp_h || d_if.read_valid !== !exp_h) begin errors++; $display("FAIL rr_rv[%0d]: got h=%b d=%b exp h=%b d=%b", k, h_if.read_valid, d_if.read_valid, exp_h, !exp_h); end
                checks++; if (h_if.data_out !== (exp_h ? 32'h1111_0001 : 32'h2222_0002)) begin errors++; $display("FAIL rr_data[%0d]: got %h exp %h", k, h_if.data_out, exp_h ? 32'h1111_0001 : 32'h2222_0002); end
            end else begin
                checks++; if (h_if.read_valid !== 1'b0 || d_if.read_valid !== 1'b0) begin errors++; $display("FAIL rr_rv_early[%0d]: got %b%b exp 00", k, h_if.read_valid, d_if.read_valid); end
            end
        end
    endtask

    task automatic test_dma_write();
        @(negedge clk); drive(1, 0, 8'h01, 32'h0, 0, 0, 8'h00, 32'h0);
        @(negedge clk); drive(0, 0, 8'h00, 32'h0, 0, 1, 8'h20, 32'h0000_00FF); #1;
        checks++; if (d_if.waitrequest !== 1'b0 || h_if.waitrequest !== 1'b0) begin errors++; $display("FAIL dma_wr_wait: got d=%b h=%b exp 0/0", d_if.waitrequest, h_if.waitrequest); end
        checks++; if (m_write !== 1'b1 || m_address !== 8'h20 || m_data_out !== 32'h0000_00FF) begin errors++; $display("FAIL dma_wr_bus: got wr=%b addr=%h data=%h exp 1/20/000000ff", m_write, m_address, m_data_out); end
        @(negedge clk); drive(1, 0, 8'h02, 32'h0, 1, 0, 8'h20, 32'h0); #1;
        checks++; if (h_if.waitrequest !== 1'b0 || d_if.waitrequest !== 1'b1 || m_address !== 8'h02) begin errors++; $display("FAIL dma_tie_next: got h=%b d=%b addr=%h exp 0/1/02", h_if.waitrequest, d_if.waitrequest, m_address); end
        @(negedge clk); drive(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0); #1;
        checks++; if (d_if.waitrequest !== 1'b0 || m_address !== 8'h20) begin errors++; $display("FAIL dma_rd_cmd: got wait=%b addr=%h exp 0/20", d_if.waitrequest, m_address); end
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk); idle(); #1;
            if (i == LAT) begin
                checks++; if (d_if.read_valid !== 1'b1 || h_if.read_valid !== 1'b0 || d_if.data_out !== 32'h0000_00FF) begin errors++; $display("FAIL dma_rd_ret: got d=%b h=%b data=%h exp 1/0/000000ff", d_if.read_valid, h_if.read_valid, d_if.data_out); end
            end
        end
    endtask

    task automatic test_read_write_same();
        @(negedge clk); drive(0, 0, 8'h00, 32'h0, 1, 1, 8'h30, 32'h1234_5678); #1;
        checks++; if (m_write !== 1'b1 || m_read !== 1'b0 || d_if.waitrequest !== 1'b0) begin errors++; $display("FAIL rw_same_cmd: got rd=%b wr=%b wait=%b exp 0/1/0", m_read, m_write, d_if.waitrequest); end
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk); idle(); #1;
            checks++; if (d_if.read_valid !== 1'b0 || h_if.read_valid !== 1'b0) begin errors++; $display("FAIL rw_same_rv: got %b%b exp 00", d_if.read_valid, h_if.read_valid); end
        end
        @(negedge clk); drive(0, 0, 8'h00, 32'h0, 1, 0, 8'h30, 32'h0);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk); idle(); #1;
            if (i == LAT) begin
                checks++; if (d_if.read_valid !== 1'b1 || d_if.data_out !== 32'h1234_5678) begin errors++; $display("FAIL rw_same_data: got rv=%b data=%h exp 1/12345678", d_if.read_valid, d_if.data_out); end
            end
        end
    endtask

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    task automatic test_fixed_priority();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); drive(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0); #1;
            checks++; if (h_if.waitrequest !== 1'b0 || d_if.waitrequest !== 1'b1 || m_address !== 8'h01) begin errors++; $display("FAIL fixed_prio[%0d]: got h=%b d=%b addr=%h exp 0/1/01", k, h_if.waitrequest, d_if.waitrequest, m_address); end
        end
        @(negedge clk); drive(0, 0, 8'h00, 32'h0, 1, 0, 8'h02, 32'h0); #1;
        checks++; if (d_if.waitrequest !== 1'b0 || m_address !== 8'h02) begin errors++; $display("FAIL fixed_dma: got wait=%b addr=%h exp 0/02", d_if.waitrequest, m_address); end
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk); idle();
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_host_alone();
        test_round_robin();
        test_dma_write();
        test_read_write_same();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        test_fixed_priority();
`endif
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
